// File: rtl/mempool_dma_chunk_scheduler.sv
// Splits one linear DMA transfer into destination-aligned chunks and deals them
// round-robin to the group's backends, reporting completion once all chunks retire.
module mempool_dma_chunk_scheduler #(
  parameter int NumBackends    = 4,
  parameter int ChunkBytes     = 256,
  parameter int MaxOutstanding = 8,
  parameter int AddrWidth      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [AddrWidth-1:0]                 req_src_i,
  input  logic [AddrWidth-1:0]                 req_dst_i,
  input  logic [31:0]                          req_num_bytes_i,
  output logic [NumBackends-1:0]               be_valid_o,
  input  logic [NumBackends-1:0]               be_ready_i,
  output logic [AddrWidth-1:0]                 be_src_o,
  output logic [AddrWidth-1:0]                 be_dst_o,
  output logic [31:0]                          be_num_bytes_o,
  input  logic [NumBackends-1:0]               be_done_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

  localparam int OW  = $clog2(MaxOutstanding + 1);
  localparam int RW  = $clog2(NumBackends);
  localparam int CBW = $clog2(ChunkBytes);
  localparam logic [31:0] ChunkLen = 32'(ChunkBytes);

  typedef enum logic [1:0] {IDLE, SPLIT, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   src_q, src_d, dst_q, dst_d;
  logic [31:0]            rem_q, rem_d;
  logic [RW-1:0]          rr_q, rr_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;
  logic                   done_q, done_d;

  logic [31:0]            room, chunk_len, done_cnt, cnt_sum;
  logic                   can_issue, dispatch;
  logic [NumBackends-1:0] rr_onehot;

  // Valid/ready: a chunk moves on backend rr in any cycle where be_valid_o[rr]
  // and be_ready_i[rr] are both high; once raised, valid and the broadcast
  // payload hold unchanged until that cycle, and valid never drops before it.
  always_comb begin
    room      = ChunkLen - {{(32-CBW){1'b0}}, dst_q[CBW-1:0]};
    chunk_len = (rem_q < room) ? rem_q : room;
    can_issue = ({{(32-OW){1'b0}}, outstanding_q} < 32'(MaxOutstanding));
    rr_onehot = {{(NumBackends-1){1'b0}}, 1'b1} << rr_q;
    be_valid_o = (state_q == SPLIT && can_issue) ? rr_onehot : '0;
    dispatch  = |(be_valid_o & be_ready_i);
  end

  // Completions that would push the count below zero are dropped.
  always_comb begin
    done_cnt = 32'd0;
    for (int i = 0; i < NumBackends; i++) begin
      done_cnt = done_cnt + {31'd0, be_done_i[i]};
    end
    cnt_sum = {{(32-OW){1'b0}}, outstanding_q} + {31'd0, dispatch};
    if (done_cnt > cnt_sum) outstanding_d = '0;
    else                    outstanding_d = OW'(cnt_sum - done_cnt);
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    rr_d    = rr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_num_bytes_i == 32'd0) begin
            done_d = 1'b1;
          end else begin
            src_d   = req_src_i;
            dst_d   = req_dst_i;
            rem_d   = req_num_bytes_i;
            state_d = SPLIT;
          end
        end
      end
      SPLIT: begin
        if (dispatch) begin
          src_d = src_q + AddrWidth'(chunk_len);
          dst_d = dst_q + AddrWidth'(chunk_len);
          rem_d = rem_q - chunk_len;
          rr_d  = rr_q + 1'b1;
          if (rem_q == chunk_len) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      rr_q          <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      rr_q          <= rr_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign outstanding_o  = outstanding_q;
  assign be_src_o       = src_q;
  assign be_dst_o       = dst_q;
  assign be_num_bytes_o = chunk_len;

  // A backend reporting more completions than chunks in flight is a system bug.
  assert property (@(posedge clk_i) disable iff (rst_i) done_cnt <= cnt_sum);

endmodule

// File: tb/tb_mempool_dma_chunk_scheduler.sv
// Directed bench for mempool_dma_chunk_scheduler: chunk splitting, rotation,
// backpressure, outstanding limit, zero-length and reset abort.
module tb_mempool_dma_chunk_scheduler;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int OW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_src_i, req_dst_i;
  logic [31:0]   req_num_bytes_i;
  logic [NB-1:0] be_valid_o, be_ready_i, be_done_i;
  logic [AW-1:0] be_src_o, be_dst_o;
  logic [31:0]   be_num_bytes_o;
  logic          busy_o, done_o;
  logic [OW-1:0] outstanding_o;

  mempool_dma_chunk_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src_i(req_src_i), .req_dst_i(req_dst_i), .req_num_bytes_i(req_num_bytes_i),
    .be_valid_o(be_valid_o), .be_ready_i(be_ready_i),
    .be_src_o(be_src_o), .be_dst_o(be_dst_o), .be_num_bytes_o(be_num_bytes_o),
    .be_done_i(be_done_i), .busy_o(busy_o), .done_o(done_o),
    .outstanding_o(outstanding_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   done_pulses = 0;
  int   last_done_cycle = -1;
  int   done_out_cycle = -2;
  bit   auto_done = 1'b0;
  logic ready_at_done = 1'b0;
  logic [NB-1:0] done_pipe [4];
  logic [99:0]   cap_q [$];
  logic [99:0]   exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: log the handshake about to happen, advance, then update backend model.
  task automatic step();
    logic [NB-1:0] hs;
    hs = be_valid_o & be_ready_i;
    if (hs != '0) cap_q.push_back({be_valid_o, be_src_o, be_dst_o, be_num_bytes_o});
    @(posedge clk_i);
    #1;
    cycle++;
    if (auto_done) begin
      be_done_i    = done_pipe[3];
      done_pipe[3] = done_pipe[2];
      done_pipe[2] = done_pipe[1];
      done_pipe[1] = done_pipe[0];
      done_pipe[0] = hs;
    end else begin
      be_done_i = '0;
    end
    if (be_done_i != '0) last_done_cycle = cycle;
    if (done_o) begin
      done_pulses++;
      done_out_cycle = cycle;
      ready_at_done  = req_ready_o;
    end
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    check("req_ready_before_start", {127'd0, req_ready_o}, 128'd1);
    req_valid_i     = 1'b1;
    req_src_i       = s;
    req_dst_i       = d;
    req_num_bytes_i = n;
    step();
    req_valid_i     = 1'b0;
    req_src_i       = 32'hDEAD_BEEF;
    req_dst_i       = 32'hCAFE_F00D;
    req_num_bytes_i = 32'h55;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_pulses;
    n = 0;
    while (done_pulses == start && n < budget) begin
      step();
      n++;
    end
    check(tag, 128'(done_pulses - start), 128'd1);
  endtask

  task automatic exp_chunk(input logic [3:0] v, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] n);
    exp_q.push_back({v, s, d, n});
  endtask

  task automatic check_chunks(input string tag);
    int n;
    check({tag, "_count"}, 128'(cap_q.size()), 128'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_chunk"}, 128'(cap_q[i]), 128'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   stable;
    int   pulses0;
    logic busy_seen, valid_seen;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_src_i = '0;
    req_dst_i = '0;
    req_num_bytes_i = '0;
    be_ready_i = '1;
    be_done_i = '0;
    for (int i = 0; i < 4; i++) done_pipe[i] = '0;

    // reset values
    #12;
    check("rst_req_ready", {127'd0, req_ready_o}, 128'd1);
    check("rst_be_valid", 128'(be_valid_o), 128'd0);
    check("rst_busy", {127'd0, busy_o}, 128'd0);
    check("rst_done", {127'd0, done_o}, 128'd0);
    check("rst_outstanding", 128'(outstanding_o), 128'd0);
    check("rst_payload", {32'd0, be_src_o, be_dst_o, be_num_bytes_o}, 128'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // 1: aligned split, rr 0..2
    auto_done = 1'b1;
    start_xfer(32'h8000_0000, 32'h0000_0100, 32'h300);
    wait_done("t1_done", 60);
    exp_chunk(4'b0001, 32'h8000_0000, 32'h100, 32'h100);
    exp_chunk(4'b0010, 32'h8000_0100, 32'h200, 32'h100);
    exp_chunk(4'b0100, 32'h8000_0200, 32'h300, 32'h100);
    check_chunks("t1");
    check("t1_done_latency", 128'(done_out_cycle - last_done_cycle), 128'd1);
    check("t1_ready_with_done", {127'd0, ready_at_done}, 128'd1);
    step();
    check("t1_done_one_cycle", {127'd0, done_o}, 128'd0);

    // 2: unaligned destination, rr continues at 3
    start_xfer(32'h1000, 32'h0000_00F0, 32'h120);
    wait_done("t2_done", 60);
    exp_chunk(4'b1000, 32'h1000, 32'h0F0, 32'h010);
    exp_chunk(4'b0001, 32'h1010, 32'h100, 32'h100);
    exp_chunk(4'b0010, 32'h1110, 32'h200, 32'h010);
    check_chunks("t2");

    // 3: zero length
    pulses0 = done_pulses;
    start_xfer(32'h5000, 32'h5000, 32'h0);
    check("t3_done_next_cycle", {127'd0, done_o}, 128'd1);
    busy_seen = busy_o;
    valid_seen = |be_valid_o;
    for (int i = 0; i < 4; i++) begin
      step();
      busy_seen  = busy_seen | busy_o;
      valid_seen = valid_seen | (|be_valid_o);
    end
    check("t3_single_done", 128'(done_pulses - pulses0), 128'd1);
    check("t3_never_busy", {127'd0, busy_seen}, 128'd0);
    check("t3_no_dispatch", {127'd0, valid_seen}, 128'd0);
    check("t3_no_chunks", 128'(cap_q.size()), 128'd0);

    // 4: backpressure on the second chunk (rr starts at 2, second chunk on backend 3)
    be_ready_i = 4'b0111;
    start_xfer(32'h2000, 32'h400, 32'h300);
    step();
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (be_valid_o === 4'b1000 && be_src_o === 32'h2100 && be_dst_o === 32'h500 &&
          be_num_bytes_o === 32'h100) stable++;
      step();
    end
    check("t4_stall_stable", 128'(stable), 128'd10);
    check("t4_no_skip_ahead", 128'(cap_q.size()), 128'd1);
    be_ready_i = '1;
    wait_done("t4_done", 60);
    exp_chunk(4'b0100, 32'h2000, 32'h400, 32'h100);
    exp_chunk(4'b1000, 32'h2100, 32'h500, 32'h100);
    exp_chunk(4'b0001, 32'h2200, 32'h600, 32'h100);
    check_chunks("t4");

    // 5: outstanding limit (rr starts at 1), dones driven by hand
    auto_done = 1'b0;
    start_xfer(32'h0, 32'h0, 32'h1000);
    for (int i = 0; i < 10; i++) step();
    check("t5_full_count", 128'(outstanding_o), 128'd8);
    check("t5_full_no_valid", 128'(be_valid_o), 128'd0);
    check("t5_eight_dispatched", 128'(cap_q.size()), 128'd8);
    be_done_i = 4'b0001;
    step();
    check("t5_after_done_count", 128'(outstanding_o), 128'd7);
    check("t5_ninth_valid", 128'(be_valid_o), 128'd2);
    step();
    check("t5_refull_count", 128'(outstanding_o), 128'd8);
    check("t5_refull_no_valid", 128'(be_valid_o), 128'd0);
    be_done_i = 4'b0010;
    step();
    check("t5_tenth_valid", 128'(be_valid_o), 128'd4);
    be_done_i = 4'b0100;
    step();
    check("t5_dispatch_and_done_net", 128'(outstanding_o), 128'd7);
    check("t5_ten_dispatched", 128'(cap_q.size()), 128'd10);
    be_ready_i = '0;
    be_done_i = 4'b0111;
    step();
    check("t5_multi_done", 128'(outstanding_o), 128'd4);
    check("t5_valid_held", 128'(be_valid_o), 128'd8);
    be_ready_i = '1;
    pulses0 = done_pulses;
    #2;
    rst_i = 1'b1;
    #1;
    check("t5_rst_outstanding", 128'(outstanding_o), 128'd0);
    check("t5_rst_busy", {127'd0, busy_o}, 128'd0);
    step();
    step();
    cap_q.delete();
    rst_i = 1'b0;

    // 6: reset after two dispatches aborts, next transfer starts on backend 0
    start_xfer(32'h3000, 32'h0, 32'h400);
    step();
    step();
    check("t6_two_dispatched", 128'(cap_q.size()), 128'd2);
    check("t6_outstanding_two", 128'(outstanding_o), 128'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_req_ready", {127'd0, req_ready_o}, 128'd1);
    check("t6_rst_valid", 128'(be_valid_o), 128'd0);
    check("t6_rst_busy", {127'd0, busy_o}, 128'd0);
    check("t6_rst_outstanding", 128'(outstanding_o), 128'd0);
    check("t6_rst_payload", {32'd0, be_src_o, be_dst_o, be_num_bytes_o}, 128'd0);
    step();
    step();
    rst_i = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 3; i++) step();
    check("t6_no_done_after_abort", 128'(done_pulses - pulses0), 128'd0);
    start_xfer(32'h4000, 32'h40, 32'h20);
    step();
    exp_chunk(4'b0001, 32'h4000, 32'h040, 32'h020);
    check_chunks("t6");
    be_done_i = 4'b0001;
    step();
    check("t6_done", {127'd0, done_o}, 128'd1);
    check("t6_ready_with_done", {127'd0, req_ready_o}, 128'd1);
    check("t6_final_outstanding", 128'(outstanding_o), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
